// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID types: the buffered {pc, inst} entry, the NOP word and a PC+4 helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package if_id_buffer_pkg;

    localparam int DATA_WIDTH = 32;

    // addi x0, x0, 0: handed to decode whenever no real instruction is queued
    localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } if_id_t;

    // Sequential PC of an instruction; wraps modulo 2^DATA_WIDTH
    function automatic logic [DATA_WIDTH-1:0] pc_plus4(input logic [DATA_WIDTH-1:0] pc);
        return pc + DATA_WIDTH'(4);
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// Elastic IF/ID boundary: small circular FIFO of {pc, inst} with a valid/ready port toward decode.
// Latency: 1 cycle from an accepted fetch to visibility on id_*; no same-cycle bypass.
// Backpressure: if_ready_o = (count < DEPTH) from registered state only; a pop while full frees space next cycle.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid_i,
    input  logic [DATA_WIDTH-1:0] if_pc_i,
    input  logic [DATA_WIDTH-1:0] if_inst_i,
    output logic                  if_ready_o,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] id_inst_o,
    input  logic                  flush_i,
    output logic [CNT_W-1:0]      occupancy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_id_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    if_id_t           head;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on count, so a pop never opens a same-cycle push
    assign if_ready_o = (count < CNT_W'(DEPTH));
    assign id_valid_o = (count != '0);
    assign occupancy_o = count;

    // Flush wins over both handshakes; the fetch word presented with it is dropped
    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = id_valid_o & id_ready_i & ~flush_i;

    assign head          = mem[rd_ptr];
    assign id_pc_o       = id_valid_o ? head.pc   : '0;
    assign id_inst_o     = id_valid_o ? head.inst : NOP_INST;
    assign id_pc_plus4_o = pc_plus4(id_pc_o);

    // Pointer and occupancy tracking; flush collapses the queue to empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage; fetch inputs are captured only on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{pc: if_pc_i, inst: if_inst_i};
        end
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Elastic IF/ID boundary between the fetch stage and the decode stage. It captures each fetched {pc, instruction} pair into a small FIFO and presents it to decode with a valid/ready handshake. Its ready output drives fetch's PC write-enable, so a decode stall back-pressures fetch without a combinational path. A synchronous flush discards all queued instructions on a redirect (branch/jump taken).

Parameters:
DEPTH, 2, number of buffered entries (>=1, need not be a power of two)
DATA_WIDTH, 32 (core_pkg), width of PC and instruction
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
if_valid_i  input  1  fetch presents a valid instruction this cycle
if_pc_i  input  DATA_WIDTH  PC of the presented instruction
if_inst_i  input  DATA_WIDTH  fetched instruction word
if_ready_o  output  1  buffer can accept; fetch uses it as pc_we
id_valid_o  output  1  head entry valid for decode
id_ready_i  input  1  decode consumes the head this cycle
id_pc_o  output  DATA_WIDTH  head PC
id_pc_plus4_o  output  DATA_WIDTH  head PC + 4
id_inst_o  output  DATA_WIDTH  head instruction, or NOP when empty
flush_i  input  1  discard all entries (synchronous)
occupancy_o  output  CNT_W  current entry count

Behaviour:
- Interface is decided: one clock; reset is asynchronous and active-high.
- State: storage array mem[DEPTH] of if_id_t, wr_ptr, rd_ptr, count.
- Reset (async assert, independent of clk): count=0, wr_ptr=rd_ptr=0, all mem entries=0.
- Resulting reset outputs: if_ready_o=1, id_valid_o=0, id_pc_o=0, id_pc_plus4_o=4, id_inst_o=NOP_INST (0x00000013), occupancy_o=0.
- if_ready_o = (count < DEPTH). It is a function of registered state only and never depends on id_ready_i or flush_i.
- id_valid_o = (count != 0). occupancy_o = count.
- When valid: id_pc_o/id_inst_o come from mem[rd_ptr]. When empty: id_pc_o=0, id_inst_o=NOP_INST.
- id_pc_plus4_o = id_pc_o + 4, truncated to DATA_WIDTH. 0xFFFFFFFC wraps to 0x00000000.
- push = if_valid_i & if_ready_o & ~flush_i
- pop = id_valid_o & id_ready_i & ~flush_i
- push: mem[wr_ptr] <= {if_pc_i, if_inst_i}; wr_ptr advances.
- pop: rd_ptr advances.
- Pointer wrap: DEPTH-1 -> 0.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an entry pushed at edge N is visible on id_* after edge N. There is no same-cycle bypass; the minimum IF->ID latency is 1 cycle.
- Full (count=DEPTH): if_ready_o=0. A pop in that cycle does not enable a push in the same cycle; ready rises the following cycle.
- Empty: id_ready_i is ignored; no underflow is possible.
- Simultaneous push+pop with 0<count<DEPTH: both occur; count is unchanged; throughput is 1 instruction/cycle.
- flush_i=1 has highest priority over push/pop: next state is count=0, wr_ptr=rd_ptr=0. mem contents are don't-care.
- On flush, if_inst_i presented that cycle is dropped. id_* still shows the pre-flush head during the flush cycle; decode must qualify it with flush.
- Reset mid-operation: all entries are lost immediately and outputs go to reset values asynchronously.
- if_valid_i=0 with if_ready_o=1 is not an error.
- Inputs are sampled only when push is true.

Decomposition:
- core_pkg additions:
  - typedef struct packed {logic [DATA_WIDTH-1:0] pc; logic [DATA_WIDTH-1:0] inst;} if_id_t
  - localparam NOP_INST = 32'h00000013
- Optionally add an if_id_if interface (valid, ready, pc, pc_plus4, inst) with MASTER/SLAVE modports, matching existing bus interfaces.
- No sub-module needed; the storage and pointer logic are inline.

Test Plan:
- Reset: assert rst mid-cycle -> outputs go to reset values without a clock edge: if_ready_o=1, id_valid_o=0, id_inst_o=0x00000013, id_pc_plus4_o=4.
- Streaming: push pc=0x0,0x4,0x8 with id_ready_i=1 continuously -> each appears 1 cycle after push; occupancy_o stays 1; id_pc_plus4_o=0x4,0x8,0xC.
- Back-pressure: id_ready_i=0, push 0x10,0x14,0x18 -> first two accepted, if_ready_o=0 at count=2, third held. Raise id_ready_i -> outputs 0x10, 0x14, then 0x18 accepted and output in order.
- Full with simultaneous pop: count=2, id_ready_i=1, if_valid_i=1 -> only pop occurs; count becomes 1; push is accepted the next cycle.
- Flush: count=2 plus push and pop asserted with flush_i=1 -> next cycle count=0, id_valid_o=0, id_inst_o=NOP; the flush-cycle instruction is never output.
- Wrap: DEPTH=3, push/pop 7 instructions pc=0x100..0x118 with random id_ready_i -> order preserved, no loss or duplication. Add a single case with pc=0xFFFFFFFC -> id_pc_plus4_o=0.
